fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//   Two-byte instruction fetch controller sitting directly upstream of the PC Register16bit.
//   Reads a 16-bit instruction from byte-wide memory at PC, then PC+1.
//   Drives the PC register's E/FunSel to post-increment after each byte.
//   Presents the assembled instruction word, little-endian, to the IR/decoder stage.
// PARAMETERS
//   TIMEOUT  15  max wait cycles per memory request before abort (FETCH_WATCHDOG_EN only)
// PORTS
//   Clock      in   1   single system clock, rising edge
//   Reset      in   1   synchronous, active-high
//   Start      in   1   begin a fetch; sampled only in IDLE
//   PCQ        in   16  current PC value (Q of PC Register16bit)
//   PCE        out  1   PC register enable
//   PCFunSel   out  2   PC register function; 2'b01 (increment) while PCE=1, else 2'b00
//   MemAddr    out  16  memory byte address; equals PCQ while MemRead=1, else 16'h0000
//   MemRead    out  1   memory read request, held until acknowledged
//   MemAck     in   1   memory acknowledge; MemData valid in the same cycle
//   MemData    in   8   memory read byte
//   IR         out  16  assembled instruction word (registered)
//   IRValid    out  1   one-cycle pulse: IR holds a complete new instruction
//   Busy       out  1   high in every state except IDLE
//   Error      out  1   one-cycle pulse on request timeout
// BEHAVIOUR
//   - Clock/reset: single clock; reset synchronous active-high, applied at the rising edge.
//   - Reset values: state=IDLE, IR=16'h0000, counter=0.
//     Combinational outputs in IDLE: IRValid=0, Error=0, PCE=0, PCFunSel=00, MemRead=0, MemAddr=0, Busy=0.
//   - Moore FSM: outputs decode from the state register only, except the capture/timeout logic below.
//   - IDLE:    Start=1 -> REQ_LO; otherwise stay.
//   - REQ_LO:  MemRead=1, MemAddr=PCQ.
//              MemAck=1 -> IR[7:0]<=MemData, go INC_LO; else stay.
//   - INC_LO:  PCE=1, PCFunSel=01 for exactly one cycle -> REQ_HI.
//   - REQ_HI:  MemRead=1, MemAddr=PCQ (already incremented).
//              MemAck=1 -> IR[15:8]<=MemData, go INC_HI; else stay.
//   - INC_HI:  PCE=1, PCFunSel=01 for exactly one cycle -> DONE.
//   - DONE:    IRValid=1 -> IDLE.
//   - Latency with zero-wait memory (ack in the first REQ cycle):
//       Start sampled at edge N; IRValid high in cycle N+5; PC advanced by exactly 2.
//     Each wait cycle on MemAck adds one cycle.
//   - IR is only written on an acknowledged REQ cycle and holds between fetches.
//     Other bytes are never touched.
//   - Start while Busy=1 is ignored, not queued. Start and IRValid may coincide; Start is still ignored.
//   - MemAck outside REQ_LO/REQ_HI is ignored.
//   - PC wrap: 16'hFFFF increments to 16'h0000 inside the PC register; no special case here.
//   - Reset mid-fetch: next cycle is IDLE, IR=0, no further PCE pulses.
//     Increments already issued are not undone.
//   - PCE is never high in two consecutive cycles and never high together with MemRead.
// CONFIGURATION
//   FETCH_WATCHDOG_EN defined:
//     - 4-bit wait counter clears on entry to each REQ state and increments per un-acked REQ cycle.
//     - When the counter reaches TIMEOUT with MemAck=0: Error=1 that cycle, state -> IDLE,
//       no IRValid, no further PC increment. A partial IR[7:0] update is retained.
//     - MemAck in the TIMEOUT cycle itself wins: no error.
//   FETCH_WATCHDOG_EN undefined:
//     - No counter; REQ states wait indefinitely; Error tied 0; TIMEOUT unused.
// TESTING
//   1 Reset held 2 cycles, then released -> all outputs 0, IR=16'h0000, Busy=0.
//   2 PC=16'h0040, mem[40]=8'h34, mem[41]=8'h12, zero-wait ack, Start pulse ->
//     MemAddr 0040 then 0041; IR=16'h1234; IRValid at N+5; PC=16'h0042.
//   3 Same fetch with 3 wait cycles before each ack ->
//     MemRead held steady; IRValid at N+11; exactly 2 PCE pulses.
//   4 PC=16'hFFFF, mem[FFFF]=8'hCD, mem[0000]=8'hAB ->
//     IR=16'hABCD; second MemAddr=16'h0000; final PC=16'h0001.
//   5 Reset asserted in REQ_HI; Start pulsed during Busy in another run ->
//     IDLE next cycle, IR=0, PC advanced by 1 only; mid-fetch Start has no effect.
//   6 FETCH_WATCHDOG_EN defined, TIMEOUT=15, MemAck never asserted in REQ_LO ->
//     Error pulse after 15 wait cycles; IDLE; no PCE; IRValid stays 0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Signal bundle linking the fetch sequencer to the PC register, byte-wide memory and the IR stage.
interface fetch_sequencer_if;
  logic        Start;
  logic [15:0] PCQ;
  logic        PCE;
  logic [1:0]  PCFunSel;
  logic [15:0] MemAddr;
  logic        MemRead;
  logic        MemAck;
  logic [7:0]  MemData;
  logic [15:0] IR;
  logic        IRValid;
  logic        Busy;
  logic        Error;

  modport master (
    input  Start, PCQ, MemAck, MemData,
    output PCE, PCFunSel, MemAddr, MemRead, IR, IRValid, Busy, Error
  );

  modport slave (
    output Start, PCQ, MemAck, MemData,
    input  PCE, PCFunSel, MemAddr, MemRead, IR, IRValid, Busy, Error
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Two-byte little-endian instruction fetch with PC post-increment after each byte.
// Optional request watchdog enabled by defining FETCH_WATCHDOG_EN.
module fetch_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  fetch_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQ_LO, INC_LO, REQ_HI, INC_HI, DONE} state_t;

  state_t      state;
  state_t      nxt;
  logic        mem_read_r;
  logic        pce_r;
  logic        irvalid_r;
  logic        busy_r;
  logic [15:0] ir_r;
  logic        in_req;
  logic        timeout;

  assign in_req = (state == REQ_LO) || (state == REQ_HI);

`ifdef FETCH_WATCHDOG_EN
  logic [3:0] wait_cnt;

  // Any state change clears the counter, which covers entry into each REQ state.
  assign timeout = in_req && !bus.MemAck && (wait_cnt == 4'(TIMEOUT));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wait_cnt <= '0;
    end else if (nxt != state) begin
      wait_cnt <= '0;
    end else if (in_req) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.Start) nxt = REQ_LO;
      REQ_LO:  if (bus.MemAck) nxt = INC_LO; else if (timeout) nxt = IDLE;
      INC_LO:  nxt = REQ_HI;
      REQ_HI:  if (bus.MemAck) nxt = INC_HI; else if (timeout) nxt = IDLE;
      INC_HI:  nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Output flags are registered from the next state so they line up with the state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      mem_read_r <= 1'b0;
      pce_r      <= 1'b0;
      irvalid_r  <= 1'b0;
      busy_r     <= 1'b0;
      ir_r       <= '0;
    end else begin
      state      <= nxt;
      mem_read_r <= (nxt == REQ_LO) || (nxt == REQ_HI);
      pce_r      <= (nxt == INC_LO) || (nxt == INC_HI);
      irvalid_r  <= (nxt == DONE);
      busy_r     <= (nxt != IDLE);
      if ((state == REQ_LO) && bus.MemAck) ir_r[7:0]  <= bus.MemData;
      if ((state == REQ_HI) && bus.MemAck) ir_r[15:8] <= bus.MemData;
    end
  end

  assign bus.PCE      = pce_r;
  assign bus.PCFunSel = pce_r ? 2'b01 : 2'b00;
  assign bus.MemRead  = mem_read_r;
  assign bus.MemAddr  = mem_read_r ? bus.PCQ : 16'h0000;
  assign bus.IR       = ir_r;
  assign bus.IRValid  = irvalid_r;
  assign bus.Busy     = busy_r;
  assign bus.Error    = timeout;
endmodule
